tdm_demux: RTL and testbench

Time-division demultiplexer that receives a serial stream of CH_NUM words from a TDM multiplexer. Each word is tagged with a valid flag, and the first word of each frame carries a start-of-frame flag. The block steers each word into the correct channel slot and presents a complete parallel frame with a one-cycle strobe. It sits at the receive end of the mux datapath and undoes the select-driven interleaving performed upstream.

---
 rtl/tdm_demux.sv | 132 +++++++++++++
 tb/tb_tdm_demux.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
`timescale 1ns/1ps
// tdm_demux: receive-side TDM demultiplexer.
// Collects CH_NUM serial words (the first tagged with in_sof) into shadow slots and
// publishes the whole frame on out_bus with a one-cycle out_valid strobe. An in_sof
// arriving before the frame completes aborts it with a one-cycle frame_err pulse and
// restarts collection with that word as channel 0.
//
// Ports:
//   sys_clk    in   clock, rising edge
//   sys_rst    in   asynchronous active-high reset
//   in_valid   in   in_0 carries a word this cycle
//   in_sof     in   word on in_0 is channel 0 of a new frame
//   in_0       in   serial data word (DATA_W)
//   sel_0      out  slot the next accepted word will fill (SEL_W)
//   out_bus    out  last complete frame, channel k at [k*DATA_W +: DATA_W]
//   out_valid  out  pulse: out_bus just took a new frame
//   frame_err  out  pulse: a partial frame was aborted by an early in_sof
module tdm_demux #(
    parameter int unsigned CH_NUM = 4,  // 2..16
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = 2   // 2**SEL_W >= CH_NUM
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [DATA_W-1:0]        in_0,
    output logic [SEL_W-1:0]         sel_0,
    output logic [CH_NUM*DATA_W-1:0] out_bus,
    output logic                     out_valid,
    output logic                     frame_err
);

    typedef enum logic [0:0] {StIdle, StRecv} state_e;

    localparam logic [SEL_W-1:0] LastSel = SEL_W'(CH_NUM - 1);

    state_e                    state_q, state_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [DATA_W-1:0]         shadow_q [CH_NUM];
    logic [DATA_W-1:0]         shadow_d [CH_NUM];
    logic [CH_NUM*DATA_W-1:0]  out_bus_q, out_bus_d;
    logic                      out_valid_q, out_valid_d;
    logic                      frame_err_q, frame_err_d;

    // State register (FSM state plus datapath registers).
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            out_bus_q   <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int k = 0; k < CH_NUM; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_bus_q   <= out_bus_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            for (int k = 0; k < CH_NUM; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    // Next-state logic. Gap cycles (in_valid=0) fall through with everything held.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        out_bus_d   = out_bus_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        for (int k = 0; k < CH_NUM; k++) begin
            shadow_d[k] = shadow_q[k];
        end

        unique case (state_q)
            StIdle: begin
                // Words without in_sof are orphans and dropped silently.
                if (in_valid && in_sof) begin
                    shadow_d[0] = in_0;
                    sel_d       = SEL_W'(1);
                    state_d     = StRecv;
                end
            end
            StRecv: begin
                if (in_valid) begin
                    if (in_sof) begin
                        // Early SOF: drop the partial frame, restart at slot 0.
                        frame_err_d = 1'b1;
                        shadow_d[0] = in_0;
                        sel_d       = SEL_W'(1);
                    end else begin
                        for (int k = 0; k < CH_NUM; k++) begin
                            if (sel_q == SEL_W'(k)) begin
                                shadow_d[k] = in_0;
                            end
                        end
                        if (sel_q == LastSel) begin
                            // Last slot bypasses the shadow so the frame lands in one edge.
                            for (int k = 0; k < CH_NUM - 1; k++) begin
                                out_bus_d[k*DATA_W +: DATA_W] = shadow_q[k];
                            end
                            out_bus_d[(CH_NUM-1)*DATA_W +: DATA_W] = in_0;
                            out_valid_d = 1'b1;
                            sel_d       = '0;
                            state_d     = StIdle;
                        end else begin
                            sel_d = sel_q + SEL_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
            end
        endcase
    end

    // Outputs are driven straight from registers.
    always_comb begin
        sel_0     = sel_q;
        out_bus   = out_bus_q;
        out_valid = out_valid_q;
        frame_err = frame_err_q;
    end

endmodule

// File: tb/tb_tdm_demux.sv
`timescale 1ns/1ps
module tb_tdm_demux;

    localparam int CH = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic              sys_clk;
    logic              sys_rst;
    logic              in_valid;
    logic              in_sof;
    logic [DW-1:0]     in_0;
    logic [SW-1:0]     sel_0;
    logic [CH*DW-1:0]  out_bus;
    logic              out_valid;
    logic              frame_err;

    int errors = 0;
    int checks = 0;

    // Reference model: the partial frame is simply a queue of collected words.
    logic [DW-1:0]     m_q [$];
    bit                m_in_frame;
    logic [CH*DW-1:0]  exp_bus;
    logic              exp_valid;
    logic              exp_err;
    logic [SW-1:0]     exp_sel;

    tdm_demux #(.CH_NUM(CH), .DATA_W(DW), .SEL_W(SW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_0      (in_0),
        .sel_0     (sel_0),
        .out_bus   (out_bus),
        .out_valid (out_valid),
        .frame_err (frame_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_q.delete();
        m_in_frame = 0;
        exp_bus    = '0;
        exp_valid  = 1'b0;
        exp_err    = 1'b0;
        exp_sel    = '0;
    endtask

    // Drive one cycle, clock it, and advance the model; samples land 1ns after the edge.
    task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
        in_valid = v;
        in_sof   = s;
        in_0     = d;
        @(posedge sys_clk);
        #1;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (v) begin
            if (s) begin
                if (m_in_frame) exp_err = 1'b1;
                m_q.delete();
                m_q.push_back(d);
                m_in_frame = 1;
            end else if (m_in_frame) begin
                m_q.push_back(d);
                if (m_q.size() == CH) begin
                    for (int k = 0; k < CH; k++) exp_bus[k*DW +: DW] = m_q[k];
                    exp_valid = 1'b1;
                    m_q.delete();
                    m_in_frame = 0;
                end
            end
        end
        exp_sel = m_in_frame ? SW'(m_q.size()) : '0;
    endtask

    task automatic test_reset();
        logic [CH*DW-1:0] f;
        sys_rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_0 = '0;
        model_reset();
        #1;
        checks++;
        if (out_bus !== '0 || sel_0 !== '0 || out_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_por: bus=%h sel=%0d v=%b e=%b, want all zero",
                     out_bus, sel_0, out_valid, frame_err);
        end
        @(posedge sys_clk); @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        f = {$urandom, $urandom};
        for (int k = 0; k < CH; k++) step(1'b1, k == 0, f[k*DW +: DW]);
        checks++;
        if (out_bus !== exp_bus || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_preframe: bus=%h v=%b, want %h v=1", out_bus, out_valid, exp_bus);
        end
        for (int i = 0; i < 5; i++) step($urandom_range(0, 1), $urandom_range(0, 1), DW'($urandom));
        // Asynchronous assertion between edges with inputs still toggling.
        #3;
        in_valid = 1'b1; in_sof = $urandom_range(0, 1); in_0 = DW'($urandom);
        sys_rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (out_bus !== '0 || sel_0 !== '0 || out_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: bus=%h sel=%0d v=%b e=%b, want all zero",
                     out_bus, sel_0, out_valid, frame_err);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk); #1;
            in_valid = $urandom_range(0, 1); in_sof = $urandom_range(0, 1); in_0 = DW'($urandom);
        end
        checks++;
        if (out_bus !== '0 || sel_0 !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: bus=%h sel=%0d v=%b, want zero", out_bus, sel_0, out_valid);
        end
        sys_rst = 1'b0;
        step(1'b0, 1'b0, '0);
    endtask

    task automatic test_nominal();
        logic [CH*DW-1:0] f;
        f = 32'hD4C3B2A1;
        for (int k = 0; k < CH; k++) begin
            checks++;
            if (sel_0 !== SW'(k)) begin
                errors++;
                $display("FAIL nominal_sel%0d: got %0d want %0d", k, sel_0, k);
            end
            step(1'b1, k == 0, f[k*DW +: DW]);
            if (k < CH - 1) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL nominal_early_valid%0d: got %b want 0", k, out_valid);
                end
            end
        end
        checks++;
        if (out_bus !== 32'hD4C3B2A1 || out_valid !== 1'b1 || sel_0 !== '0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL nominal_frame: bus=%h v=%b sel=%0d e=%b, want D4C3B2A1 1 0 0",
                     out_bus, out_valid, sel_0, frame_err);
        end
        step(1'b0, 1'b0, '0);
        checks++;
        if (out_valid !== 1'b0 || out_bus !== 32'hD4C3B2A1) begin
            errors++;
            $display("FAIL nominal_pulse_end: v=%b bus=%h, want 0 D4C3B2A1", out_valid, out_bus);
        end
    endtask

    task automatic test_gapped();
        logic [CH*DW-1:0] f;
        int pulses;
        f = 32'hD4C3B2A1;
        pulses = 0;
        for (int k = 0; k < CH; k++) begin
            step(1'b1, k == 0, f[k*DW +: DW]);
            pulses += int'(out_valid);
            for (int g = 0; g < 3; g++) begin
                step(1'b0, $urandom_range(0, 1), DW'($urandom));
                pulses += int'(out_valid);
                checks++;
                if (sel_0 !== SW'((k + 1) % CH)) begin
                    errors++;
                    $display("FAIL gapped_sel_hold: got %0d want %0d", sel_0, (k + 1) % CH);
                end
            end
        end
        checks++;
        if (pulses != 1 || out_bus !== 32'hD4C3B2A1) begin
            errors++;
            $display("FAIL gapped_frame: pulses=%0d bus=%h, want 1 D4C3B2A1", pulses, out_bus);
        end
    endtask

    task automatic test_early_sof();
        logic [6*DW-1:0] d;
        logic [5:0]      s;
        d = 48'h665544332211;
        s = 6'b000101;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, s[i], d[i*DW +: DW]);
            checks++;
            if (frame_err !== (i == 2) || out_valid !== (i == 5)) begin
                errors++;
                $display("FAIL early_sof_pulse%0d: err=%b v=%b, want %b %b",
                         i, frame_err, out_valid, i == 2, i == 5);
            end
            if (i == 2) begin
                checks++;
                if (out_bus !== 32'hD4C3B2A1 || sel_0 !== SW'(1)) begin
                    errors++;
                    $display("FAIL early_sof_hold: bus=%h sel=%0d, want D4C3B2A1 1", out_bus, sel_0);
                end
            end
        end
        checks++;
        if (out_bus !== 32'h66554433) begin
            errors++;
            $display("FAIL early_sof_frame: got %h want 66554433", out_bus);
        end
        step(1'b0, 1'b0, '0);
        checks++;
        if (frame_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_sof_end: err=%b v=%b, want 0 0", frame_err, out_valid);
        end
    endtask

    task automatic test_orphans();
        logic [CH*DW-1:0] f;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, DW'($urandom));
            checks++;
            if (frame_err !== 1'b0 || out_valid !== 1'b0 || sel_0 !== '0) begin
                errors++;
                $display("FAIL orphan%0d: err=%b v=%b sel=%0d, want 0 0 0",
                         i, frame_err, out_valid, sel_0);
            end
        end
        f = {$urandom, $urandom};
        for (int k = 0; k < CH; k++) step(1'b1, k == 0, f[k*DW +: DW]);
        checks++;
        if (out_bus !== f || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL orphan_frame: bus=%h v=%b, want %h 1", out_bus, out_valid, f);
        end
    endtask

    task automatic test_back_to_back();
        logic [CH*DW-1:0] f1, f2;
        int p [$];
        f1 = {$urandom, $urandom};
        f2 = {$urandom, $urandom};
        for (int j = 0; j < 2 * CH; j++) begin
            step(1'b1, (j % CH) == 0, (j < CH) ? f1[j*DW +: DW] : f2[(j-CH)*DW +: DW]);
            if (out_valid === 1'b1) p.push_back(j);
            if (j == CH - 1) begin
                checks++;
                if (out_bus !== f1) begin
                    errors++;
                    $display("FAIL b2b_frame1: got %h want %h", out_bus, f1);
                end
            end
        end
        checks++;
        if (p.size() != 2 || out_bus !== f2) begin
            errors++;
            $display("FAIL b2b_frame2: pulses=%0d bus=%h, want 2 %h", p.size(), out_bus, f2);
        end else begin
            checks++;
            if (p[1] - p[0] != CH) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d want %0d", p[1] - p[0], CH);
            end
        end
        // Third frame cut short by reset after two words.
        step(1'b1, 1'b1, DW'($urandom));
        step(1'b1, 1'b0, DW'($urandom));
        in_valid = 1'b1; in_sof = 1'b0; in_0 = DW'($urandom);
        #3;
        sys_rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (out_bus !== '0 || sel_0 !== '0 || out_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: bus=%h sel=%0d v=%b e=%b, want all zero",
                     out_bus, sel_0, out_valid, frame_err);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, DW'($urandom));
            checks++;
            if (out_valid !== 1'b0 || frame_err !== 1'b0 || sel_0 !== '0 || out_bus !== '0) begin
                errors++;
                $display("FAIL post_reset%0d: v=%b e=%b sel=%0d bus=%h, want 0 0 0 0",
                         i, out_valid, frame_err, sel_0, out_bus);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, DW'($urandom));
            checks++;
            if (out_bus !== exp_bus || out_valid !== exp_valid || frame_err !== exp_err ||
                sel_0 !== exp_sel) begin
                errors++;
                $display("FAIL random%0d: bus=%h v=%b e=%b sel=%0d, want %h %b %b %0d",
                         i, out_bus, out_valid, frame_err, sel_0,
                         exp_bus, exp_valid, exp_err, exp_sel);
            end
            checks++;
            if (out_valid === 1'b1 && frame_err === 1'b1) begin
                errors++;
                $display("FAIL random_both%0d: out_valid=1 frame_err=1, want not both", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gapped();
        test_early_sof();
        test_orphans();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
